// File: rtl/eth_measurer_pkg.sv
// Constants, state encoding and length clamp shared by the measurer TX and RX paths.
package eth_measurer_pkg;

   localparam logic [47:0] BROADCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [15:0] HEADER_LEN    = 16'd26;
   localparam logic [15:0] MIN_FRAME_LEN = 16'd60;
   localparam logic [15:0] MAX_FRAME_LEN = 16'd1514;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      PAD    = 2'd2
   } meas_state_t;

   function automatic logic [15:0] clamp_len(input logic [15:0] len);
      logic [15:0] res;
      res = len;
      if (len < MIN_FRAME_LEN) res = MIN_FRAME_LEN;
      else if (len > MAX_FRAME_LEN) res = MAX_FRAME_LEN;
      return res;
   endfunction

endpackage

// File: rtl/eth_measurer_tx.sv
// Ping frame generator: broadcast header + ping_id, zero-padded to the clamped length.
// One beat per cycle from the cycle after trigger; outputs hold while tready is low.
module eth_measurer_tx
   import eth_measurer_pkg::*;
#(
   parameter logic [47:0] src_mac    = 48'h00_00_00_00_00_00,
   parameter logic [31:0] identifier = 32'h00_00_00_00,
   parameter logic [15:0] ethertype  = 16'h88B5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trigger,
   input  logic [63:0] ping_id,
   input  logic [15:0] frame_len,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tkeep,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready
);

   meas_state_t r_state, w_state_nxt;
   logic [15:0] r_cnt,  w_cnt_nxt;
   logic [15:0] r_len,  w_len_nxt;
   logic [63:0] r_ping, w_ping_nxt;
   logic        r_done, w_done_nxt;

   logic         w_active;
   logic         w_beat;
   logic         w_last;
   logic [207:0] w_hdr;
   logic [7:0]   w_hdr_byte;

   assign w_active = (r_state != IDLE);
   assign w_beat   = w_active && m_axis_tready;
   assign w_last   = (r_state == PAD) && (r_cnt == r_len - 16'd1);

   // Header laid out MSB-first so byte k sits at bits [8*(25-k) +: 8].
   assign w_hdr      = {BROADCAST_MAC, src_mac, ethertype, identifier, r_ping};
   assign w_hdr_byte = 8'(w_hdr >> {5'd25 - r_cnt[4:0], 3'b000});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_len   <= MIN_FRAME_LEN;
         r_ping  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_len   <= w_len_nxt;
         r_ping  <= w_ping_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      w_ping_nxt  = r_ping;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (trigger) begin
               w_state_nxt = HEADER;
               w_cnt_nxt   = '0;
               w_len_nxt   = clamp_len(frame_len);
               w_ping_nxt  = ping_id;
            end
         end
         HEADER: begin
            if (w_beat) begin
               w_cnt_nxt = r_cnt + 16'd1;
               if (r_cnt == HEADER_LEN - 16'd1) w_state_nxt = PAD;
            end
         end
         PAD: begin
            // Clamped length is at least 60, so the tlast beat always falls in PAD.
            if (w_beat) begin
               if (w_last) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 16'd1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign busy          = w_active;
   assign frame_done    = r_done;
   assign m_axis_tvalid = w_active;
   assign m_axis_tkeep  = w_active;
   assign m_axis_tlast  = w_last;
   assign m_axis_tdata  = (r_state == HEADER) ? w_hdr_byte : 8'h00;

endmodule
